// File: rtl/pattern_scheduler_if.sv
// Pattern scheduler bus: control, table write port,
// pattern-generator drive and status, grouped for one port.
interface pattern_scheduler_if;
  logic        start;
  logic        stop;
  logic [1:0]  n_entries;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [18:0] wr_data;
  logic        wr_ack;
  logic        f_sync;
  logic        sync;
  logic [11:0] constVal;
  logic [1:0]  X;
  logic [1:0]  Y;
  logic [2:0]  Mode;
  logic        busy;
  logic [1:0]  entry_idx;
  logic        frame_done;

  modport master (
    output start, stop, n_entries,
    output wr_en, wr_idx, wr_data,
    input  wr_ack, f_sync, sync,
    input  constVal, X, Y, Mode,
    input  busy, entry_idx, frame_done
  );

  modport slave (
    input  start, stop, n_entries,
    input  wr_en, wr_idx, wr_data,
    output wr_ack, f_sync, sync,
    output constVal, X, Y, Mode,
    output busy, entry_idx, frame_done
  );
endinterface

// File: rtl/pattern_scheduler.sv
// Frame/line sync scheduler stepping through a 4-entry config table.
// Define PATTERN_SCHED_LOOP_EN to loop over entries until stop.
module pattern_scheduler #(
  parameter int LINE_CYCLES     = 64,
  parameter int LINES_PER_FRAME = 8
) (
  input logic                clk,
  input logic                rst_n,
  pattern_scheduler_if.slave bus
);

  localparam int CW =
    (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
  localparam int LW =
    (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FSYNC,
    LINE
  } state_t;

  state_t         state;
  logic [18:0]    tbl [4];
  logic [CW-1:0]  cycle_cnt;
  logic [LW-1:0]  line_cnt;
  logic           stop_pending;

  logic           cyc_last;
  logic           line_last;
  logic           frame_end;
  logic           pre_end;
  logic           entry_wrap;
  logic [1:0]     next_idx;
  logic           run_done;
  logic           go_idle;

  // Frame position decode and next-entry selection.
  always_comb begin
    cyc_last   = cycle_cnt == CW'(LINE_CYCLES - 1);
    line_last  = line_cnt == LW'(LINES_PER_FRAME - 1);
    frame_end  = (state == LINE) && cyc_last && line_last;
    pre_end    = (state == LINE) && line_last &&
                 (cycle_cnt == CW'(LINE_CYCLES - 2));
    entry_wrap = bus.entry_idx >= bus.n_entries;
    next_idx   = entry_wrap ? 2'd0 : bus.entry_idx + 2'd1;
`ifdef PATTERN_SCHED_LOOP_EN
    run_done   = 1'b0;
`else
    run_done   = entry_wrap;
`endif
    go_idle    = bus.stop || stop_pending || run_done;
  end

  // Config table write port; writes land in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) tbl[i] <= '0;
      bus.wr_ack <= 1'b0;
    end else begin
      bus.wr_ack <= bus.wr_en;
      if (bus.wr_en) tbl[bus.wr_idx] <= bus.wr_data;
    end
  end

  // Scheduler FSM with registered sync, status and config outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cycle_cnt      <= '0;
      line_cnt       <= '0;
      stop_pending   <= 1'b0;
      bus.f_sync     <= 1'b0;
      bus.sync       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.busy       <= 1'b0;
      bus.entry_idx  <= '0;
      bus.constVal   <= '0;
      bus.X          <= '0;
      bus.Y          <= '0;
      bus.Mode       <= '0;
    end else begin
      bus.f_sync     <= 1'b0;
      bus.sync       <= 1'b0;
      bus.frame_done <= 1'b0;
      if (state != IDLE && bus.stop) stop_pending <= 1'b1;
      unique case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          if (bus.start && !bus.stop) begin
            state      <= FSYNC;
            bus.f_sync <= 1'b1;
            bus.busy   <= 1'b1;
            {bus.Mode, bus.Y, bus.X, bus.constVal}
              <= tbl[bus.entry_idx];
          end
        end
        FSYNC: begin
          state     <= LINE;
          bus.sync  <= 1'b1;
          cycle_cnt <= '0;
          line_cnt  <= '0;
        end
        LINE: begin
          if (frame_end) begin
            bus.entry_idx <= next_idx;
            if (go_idle) begin
              state        <= IDLE;
              bus.busy     <= 1'b0;
              stop_pending <= 1'b0;
            end else begin
              state      <= FSYNC;
              bus.f_sync <= 1'b1;
              {bus.Mode, bus.Y, bus.X, bus.constVal}
                <= tbl[next_idx];
            end
          end else begin
            bus.frame_done <= pre_end;
            if (cyc_last) begin
              cycle_cnt <= '0;
              line_cnt  <= line_cnt + LW'(1);
              bus.sync  <= 1'b1;
            end else begin
              cycle_cnt <= cycle_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler: vector table with a
// scoreboard queue plus hand sequences for multi-frame and reset cases.
module tb_pattern_scheduler;
  localparam int LC  = 4;
  localparam int LPF = 2;
  localparam int FL  = LC * LPF;
`ifdef PATTERN_SCHED_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #8 clk = ~clk;

  pattern_scheduler_if bus ();

  pattern_scheduler #(
    .LINE_CYCLES    (LC),
    .LINES_PER_FRAME(LPF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [1:0] n;
    logic       st;
    logic       sp;
    logic       fs;
    logic       sy;
    logic       fd;
    logic       bz;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row j: inputs sampled at start-edge t+j, outputs of cycle t+j+1.
  function automatic vec_t mk(logic [1:0] n, logic st,
                              logic sp, int j, bit act);
    vec_t v;
    v.n  = n;
    v.st = st;
    v.sp = sp;
    v.fs = act && (j == 0);
    v.sy = act && (j >= 1) && (j <= FL) &&
           ((j - 1) % LC == 0);
    v.fd = act && (j == FL);
    v.bz = act && (j <= FL);
    return v;
  endfunction

  task automatic wait_idle(int max);
    int k;
    k = 0;
    while (bus.busy && k < max) begin
      tick();
      k++;
    end
    chk("idle_timeout", 32'(bus.busy), 0);
  endtask

  task automatic wr(logic [1:0] idx, logic [18:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = idx;
    bus.wr_data = d;
    tick();
    chk("wr_ack", 32'(bus.wr_ack), 1);
    bus.wr_en = 1'b0;
  endtask

  initial begin
    vec_t v;
    vec_t e;
    logic [18:0] w0;
    logic [18:0] w1;
    logic [1:0] got[$];
    logic [1:0] expq[$];
    logic [31:0] g;
    int k;

    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.n_entries = 2'd0;
    bus.wr_en     = 1'b0;
    bus.wr_idx    = 2'd0;
    bus.wr_data   = '0;

    // Stop-mid-frame with n=1 leaves entry 1 selected; the
    // start-held run then reads entry 1 and wraps to 0.
    for (int j = 0; j < 12; j++)
      vecs.push_back(mk(2'd1, j == 0, j == 4, j, 1));
    for (int j = 0; j < 4; j++)
      vecs.push_back(mk(2'd0, j < 3, j < 3, j, 0));
    for (int j = 0; j < 12; j++)
      vecs.push_back(mk(2'd0, j <= 9, LOOP && j == 4, j, 1));
    for (int j = 0; j < 12; j++)
      vecs.push_back(mk(2'd0, j == 0, LOOP && j == 4, j, 1));

    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_fsync", 32'(bus.f_sync), 0);
    chk("rst_sync", 32'(bus.sync), 0);
    chk("rst_const", 32'(bus.constVal), 0);
    chk("rst_idx", 32'(bus.entry_idx), 0);
    rst_n = 1'b1;
    tick();

    w0 = 19'h12345;
    w1 = 19'h7FFFF;
    wr(2'd0, w0);
    tick();
    chk("wr_ack_low", 32'(bus.wr_ack), 0);
    wr(2'd1, w1);

    foreach (vecs[i]) begin
      v = vecs[i];
      bus.n_entries = v.n;
      bus.start     = v.st;
      bus.stop      = v.sp;
      sb.push_back(v);
      tick();
      e = sb.pop_front();
      chk("f_sync", 32'(bus.f_sync), 32'(e.fs));
      chk("sync", 32'(bus.sync), 32'(e.sy));
      chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
      chk("busy", 32'(bus.busy), 32'(e.bz));
      chk("fs_sync_excl",
          32'(bus.f_sync & bus.sync), 0);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    chk("cfg_const", 32'(bus.constVal), 32'(w0[11:0]));
    chk("cfg_x", 32'(bus.X), 32'(w0[13:12]));
    chk("cfg_y", 32'(bus.Y), 32'(w0[15:14]));
    chk("cfg_mode", 32'(bus.Mode), 32'(w0[18:16]));

    // Rewrite the active entry mid-frame.
    bus.n_entries = 2'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rw_fsync", 32'(bus.f_sync), 1);
    tick();
    tick();
    wr(2'd0, 19'h5ABCD);
    chk("rw_hold_const", 32'(bus.constVal), 32'(w0[11:0]));
    chk("rw_hold_mode", 32'(bus.Mode), 32'(w0[18:16]));
    bus.stop = LOOP;
    wait_idle(20);
    bus.stop = 1'b0;
    chk("rw_idle_const", 32'(bus.constVal), 32'(w0[11:0]));
    w0 = 19'h5ABCD;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rw_new_fsync", 32'(bus.f_sync), 1);
    chk("rw_new_const", 32'(bus.constVal), 32'(w0[11:0]));
    chk("rw_new_x", 32'(bus.X), 32'(w0[13:12]));
    chk("rw_new_y", 32'(bus.Y), 32'(w0[15:14]));
    chk("rw_new_mode", 32'(bus.Mode), 32'(w0[18:16]));
    bus.stop = LOOP;
    wait_idle(20);
    bus.stop = 1'b0;

    // Multi-frame entry sequence with n_entries=2.
    bus.n_entries = 2'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (bus.f_sync) got.push_back(bus.entry_idx);
    expq = LOOP ? '{2'd0, 2'd1, 2'd2, 2'd0}
                : '{2'd0, 2'd1, 2'd2};
    k = 0;
    while (k < 60 && (LOOP ? got.size() < 4 : 1'b1)) begin
      tick();
      if (bus.f_sync) got.push_back(bus.entry_idx);
      k++;
    end
    bus.stop = LOOP;
    wait_idle(20);
    bus.stop = 1'b0;
    chk("n_frames", 32'(got.size()), 32'(expq.size()));
    foreach (expq[i]) begin
      g = (i < got.size()) ? 32'(got[i]) : '1;
      chk("idx_seq", g, 32'(expq[i]));
    end
    if (!LOOP) chk("end_idx", 32'(bus.entry_idx), 0);

    // Asynchronous reset in the middle of the second frame.
    bus.n_entries = 2'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    tick();
    while (!bus.f_sync && k < 20) begin
      tick();
      k++;
    end
    chk("rs_second_fsync", 32'(bus.f_sync), 1);
    chk("rs_idx1", 32'(bus.entry_idx), 1);
    chk("rs_const1", 32'(bus.constVal), 32'(w1[11:0]));
    repeat (4) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rs_busy", 32'(bus.busy), 0);
    chk("rs_const", 32'(bus.constVal), 0);
    chk("rs_mode", 32'(bus.Mode), 0);
    chk("rs_idx", 32'(bus.entry_idx), 0);
    chk("rs_sync", 32'(bus.sync), 0);
    tick();
    chk("rs_no_fdone", 32'(bus.frame_done), 0);
    rst_n = 1'b1;
    tick();
    chk("rs_no_fdone2", 32'(bus.frame_done), 0);
    chk("rs_idle", 32'(bus.busy), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rs_restart_fsync", 32'(bus.f_sync), 1);
    chk("rs_restart_idx", 32'(bus.entry_idx), 0);
    chk("rs_tbl_cleared", 32'(bus.constVal), 0);
    bus.stop = 1'b1;
    wait_idle(20);
    bus.stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
